// File: rtl/semaphore_sequencer_if.sv
// Bundle between the intersection sequencer and its upstream/unit side.
// master: drives run and the per-unit done lines, observes the sequencer outputs.
// slave:  the sequencer itself.
interface semaphore_sequencer_if #(
    parameter int N_UNITS = 2,
    parameter int IDXW    = $clog2(N_UNITS)
);
    logic                run;
    logic [N_UNITS-1:0]  done;
    logic [N_UNITS-1:0]  en;
    logic [N_UNITS-1:0]  next;
    logic [IDXW-1:0]     active;
    logic [1:0]          step;
    logic                busy;
    logic                fault;

    modport master (
        output run, done,
        input  en, next, active, step, busy, fault
    );

    modport slave (
        input  run, done,
        output en, next, active, step, busy, fault
    );
endinterface

// File: rtl/semaphore_sequencer.sv
// Intersection sequencer: enables all semaphore units, paces the active unit
// through its four light steps with timed single-cycle next pulses, waits for
// that unit's done and hands over round-robin.
// Optional feature: define SEQ_DONE_TIMEOUT_EN to add a sticky done-timeout
// FAULT state; without it WAIT_DONE waits indefinitely and fault is tied 0.
module semaphore_sequencer #(
    parameter int N_UNITS      = 2,
    parameter int T_STEP0      = 8,
    parameter int T_STEP1      = 3,
    parameter int T_STEP2      = 8,
    parameter int T_STEP3      = 2,
    parameter int DONE_TIMEOUT = 16,
    parameter int IDXW         = $clog2(N_UNITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    semaphore_sequencer_if.slave   bus
);

    localparam int TM01    = (T_STEP0 > T_STEP1) ? T_STEP0 : T_STEP1;
    localparam int TM23    = (T_STEP2 > T_STEP3) ? T_STEP2 : T_STEP3;
    localparam int TM_ALL  = (TM01 > TM23) ? TM01 : TM23;
    localparam int CNT_MAX = (TM_ALL > DONE_TIMEOUT) ? TM_ALL : DONE_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

`ifdef SEQ_DONE_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_DWELL, S_PULSE, S_WAIT, S_FAULT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_DWELL, S_PULSE, S_WAIT} state_t;
`endif

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          step_q, step_d;
    logic [IDXW-1:0]     active_q, active_d;
    logic [N_UNITS-1:0]  en_q, en_d;
    logic [N_UNITS-1:0]  next_q, next_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;

    logic [N_UNITS-1:0]  onehot;
    logic [CW-1:0]       cnt_inc;
    logic [CW-1:0]       dwell_end;
    logic                done_active;

    // One-hot decode of the active index, one bit per unit.
    genvar gi;
    generate
        for (gi = 0; gi < N_UNITS; gi++) begin : g_onehot
            assign onehot[gi] = (active_q == IDXW'(gi));
        end
    endgenerate

    // Saturating increment; the counter never wraps back to zero.
    assign cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    assign done_active = bus.done[active_q];

    // Last dwell count for the step whose pulse is pending.
    always_comb begin
        dwell_end = CW'(T_STEP0 - 1);
        case (step_q)
            2'd0: dwell_end = CW'(T_STEP0 - 1);
            2'd1: dwell_end = CW'(T_STEP1 - 1);
            2'd2: dwell_end = CW'(T_STEP2 - 1);
            2'd3: dwell_end = CW'(T_STEP3 - 1);
            default: dwell_end = CW'(T_STEP0 - 1);
        endcase
    end

    // State and output registers; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            active_q <= '0;
            en_q     <= '0;
            next_q   <= '0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            active_q <= active_d;
            en_q     <= en_d;
            next_q   <= next_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic: run=0 always wins and returns everything to IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        active_d = active_q;
        if (!bus.run) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            step_d   = '0;
            active_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_DWELL;
                    cnt_d    = '0;
                    step_d   = '0;
                    active_d = '0;
                end
                S_DWELL: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == dwell_end) begin
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    cnt_d = '0;
                    if (step_q == 2'd3) begin
                        step_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = S_DWELL;
                    end
                end
                S_WAIT: begin
                    if (done_active) begin
                        state_d  = S_DWELL;
                        cnt_d    = '0;
                        active_d = (active_q == IDXW'(N_UNITS - 1)) ? '0 : active_q + 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
`ifdef SEQ_DONE_TIMEOUT_EN
                        if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                            state_d = S_FAULT;
                        end
`endif
                    end
                end
`ifdef SEQ_DONE_TIMEOUT_EN
                S_FAULT: begin
                    state_d = S_FAULT;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode; the pulse lands one edge after the PULSE state, and a
    // PULSE cycle that coincides with run=0 issues nothing.
    always_comb begin
        next_d  = (state_q == S_PULSE && bus.run) ? onehot : '0;
        busy_d  = (state_d != S_IDLE);
`ifdef SEQ_DONE_TIMEOUT_EN
        en_d    = (state_d != S_IDLE && state_d != S_FAULT) ? {N_UNITS{1'b1}} : '0;
        fault_d = (state_d == S_FAULT);
`else
        en_d    = (state_d != S_IDLE) ? {N_UNITS{1'b1}} : '0;
        fault_d = 1'b0;
`endif
    end

    assign bus.en     = en_q;
    assign bus.next   = next_q;
    assign bus.active = active_q;
    assign bus.step   = step_q;
    assign bus.busy   = busy_q;
    assign bus.fault  = fault_q;

endmodule

// File: tb/tb_semaphore_sequencer.sv
// Self-checking bench for semaphore_sequencer with N_UNITS=2,
// T_STEP0..3 = 2,1,3,1 and DONE_TIMEOUT=4. A timeline model (countdown to the
// next visible pulse, wait-cycle tally) predicts every output each cycle.
module tb_semaphore_sequencer;

    localparam int N  = 2;
    localparam int DT = 4;

    logic clk;
    logic reset;

    semaphore_sequencer_if #(.N_UNITS(N)) sif ();

    semaphore_sequencer #(
        .N_UNITS(N), .T_STEP0(2), .T_STEP1(1), .T_STEP2(3), .T_STEP3(1),
        .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    int tdwell [4] = '{2, 1, 3, 1};

    // Reference model: m_left = edges until the next pulse shows up.
    bit         m_on, m_wait, m_fault;
    int         m_act, m_step, m_left, m_wcnt;
    logic [1:0] m_next;
    logic [1:0] prev_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_wait = 0; m_fault = 0;
        m_act = 0; m_step = 0; m_left = 0; m_wcnt = 0;
        m_next = 2'b00;
    endtask

    task automatic model_edge();
        m_next = 2'b00;
        if (reset || !sif.run) begin
            model_reset();
        end else if (!m_on) begin
            m_on = 1; m_act = 0; m_step = 0; m_wait = 0; m_fault = 0;
            m_left = tdwell[0] + 1;
        end else if (m_fault) begin
            // parked until run drops
        end else if (m_wait) begin
            if (sif.done[m_act]) begin
                m_act  = (m_act + 1) % N;
                m_wait = 0;
                m_left = tdwell[0] + 1;
            end else begin
                m_wcnt++;
`ifdef SEQ_DONE_TIMEOUT_EN
                if (m_wcnt == DT) m_fault = 1;
`endif
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_next = 2'b01 << m_act;
                if (m_step == 3) begin
                    m_step = 0; m_wait = 1; m_wcnt = 0;
                end else begin
                    m_step++;
                    m_left = tdwell[m_step] + 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cycle++;
        check("en",     32'(sif.en),     32'((m_on && !m_fault) ? 2'b11 : 2'b00));
        check("next",   32'(sif.next),   32'(m_next));
        check("active", 32'(sif.active), 32'(m_act));
        check("step",   32'(sif.step),   32'(m_step));
        check("busy",   32'(sif.busy),   32'(m_on));
        check("fault",  32'(sif.fault),  32'(m_fault));
        check("next_gap", 32'((prev_next != 0) && (sif.next != 0)), 32'(0));
        if (sif.next != 0)
            $display("cycle %0d: pulse next=%b active=%0d step_now=%0d", cycle, sif.next, sif.active, sif.step);
        prev_next = sif.next;
    endtask

    int n;

    initial begin
        reset = 1'b1;
        sif.run  = 1'b0;
        sif.done = 2'b00;
        prev_next = 2'b00;
        model_reset();

        // 1. reset held with run=1: everything stays at reset values
        sif.run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;

        // 2/3. done[1] held while unit 0 runs: ignored; then handover via done[0]
        sif.done = 2'b10;
        n = 0;
        while (!m_wait && n < 60) begin tick(); n++; end
        check("reach_wait0", 32'(n < 60), 32'(1));
        tick(); tick();
        check("ignore_done1", 32'(sif.active), 32'(0));
        sif.done = 2'b01;
        tick();
        check("handover_0to1", 32'(sif.active), 32'(1));
        sif.done = 2'b00;

        // done[1] already high on WAIT entry: handover on the first wait cycle
        sif.done = 2'b10;
        n = 0;
        while (!m_wait && n < 60) begin tick(); n++; end
        check("reach_wait1", 32'(n < 60), 32'(1));
        tick();
        check("wrap_1to0", 32'(sif.active), 32'(0));
        sif.done = 2'b00;

        // 4. run=0 during DWELL of step 2 on unit 1
        sif.done = 2'b01;
        n = 0;
        while (!(m_act == 1 && m_step == 2 && !m_wait && m_left == 3) && n < 80) begin
            tick(); n++;
            if (m_act == 1) sif.done = 2'b00;
        end
        check("reach_u1_s2", 32'(n < 80), 32'(1));
        sif.run = 1'b0;
        tick();
        check("stop_busy",   32'(sif.busy),   32'(0));
        check("stop_en",     32'(sif.en),     32'(0));
        check("stop_active", 32'(sif.active), 32'(0));
        sif.run = 1'b1;
        n = 0;
        while (sif.next == 2'b00 && n < 20) begin tick(); n++; end
        check("restart_first_pulse", 32'(sif.next), 32'(2'b01));

        // 5. asynchronous reset between edges while a pulse is visible
        n = 0;
        while (sif.next == 2'b00 && n < 20) begin tick(); n++; end
        check("pulse_before_reset", 32'(sif.next != 0), 32'(1));
        reset = 1'b1;
        #1;
        check("async_next",  32'(sif.next),   32'(0));
        check("async_en",    32'(sif.en),     32'(0));
        check("async_busy",  32'(sif.busy),   32'(0));
        check("async_step",  32'(sif.step),   32'(0));
        check("async_active",32'(sif.active), 32'(0));
        model_reset();
        prev_next = 2'b00;
        tick(); tick();
        reset = 1'b0;

        // 6. done never returned
        sif.done = 2'b00;
        n = 0;
        while (!m_wait && n < 60) begin tick(); n++; end
        check("reach_wait_to", 32'(n < 60), 32'(1));
        for (int i = 0; i < 8; i++) tick();
`ifdef SEQ_DONE_TIMEOUT_EN
        check("timeout_fault", 32'(sif.fault), 32'(1));
        check("timeout_en",    32'(sif.en),    32'(0));
        sif.run = 1'b0;
        tick();
        check("fault_cleared", 32'(sif.fault), 32'(0));
        sif.run = 1'b1;
`else
        check("no_fault",      32'(sif.fault), 32'(0));
        check("still_waiting", 32'(sif.busy),  32'(1));
        check("still_en",      32'(sif.en),    32'(2'b11));
        sif.run = 1'b0;
        tick();
        sif.run = 1'b1;
`endif

        // randomized run/done traffic against the model
        for (int i = 0; i < 600; i++) begin
            sif.run     = ($urandom_range(0, 39) != 0);
            sif.done[0] = ($urandom_range(0, 3) == 0);
            sif.done[1] = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
